// File: rtl/bin_to_bcd_converter.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_converter
//
// Converts an unsigned binary value into packed BCD using the shift-and-add-3
// (double dabble) algorithm, one input bit per clock. A small three-state FSM
// (IDLE -> SHIFT -> DONE -> IDLE) sequences the conversion. The result and
// its significant-digit count are only updated when a conversion completes,
// so the outputs never show a partially converted value.
//
// DIGITS must be large enough that 10^DIGITS > 2^WIDTH - 1, and no larger
// than 7 so that the digit count fits the 3-bit SigDigits output.
//
// Ports
//   Clk        : clock; every register updates on its rising edge
//   Reset      : synchronous, active-high reset
//   Start      : conversion request, honoured only while idle
//   Auto       : when high, start automatically whenever BinIn differs from
//                the value captured by the previous conversion
//   BinIn      : WIDTH-bit unsigned value to convert
//   Bcd        : registered result, digit i in bits [4i+3:4i], digit 0 = LSD
//   SigDigits  : registered count of significant digits (1..DIGITS)
//   Busy       : high while the FSM is shifting
//   Done       : one-cycle pulse when Bcd/SigDigits carry a new result
// ---------------------------------------------------------------------------
module bin_to_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Auto,
  input  logic [WIDTH-1:0]      BinIn,
  output logic [4*DIGITS-1:0]   Bcd,
  output logic [2:0]            SigDigits,
  output logic                  Busy,
  output logic                  Done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [BCD_W-1:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      last_bin_q, last_bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [2:0]            sig_q, sig_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  trigger;
  logic [BCD_W-1:0]      adjusted;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic [BCD_W-1:0]      next_scratch;
  logic [WIDTH-1:0]      next_shift;
  logic [2:0]            next_sig;

  // Next-state logic. One double-dabble step is computed every cycle but is
  // only committed while shifting. The add-3 correction is applied per digit
  // in 4 bits with no carry into the neighbour, which keeps each digit <= 9
  // after the following shift. Busy and Done are derived from the next state
  // so that they come out of flops aligned with the state register.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    last_bin_d = last_bin_q;
    bcd_d      = bcd_q;
    sig_d      = sig_q;

    trigger = Start || (Auto && (BinIn != last_bin_q));

    adjusted = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end

    shifted      = {adjusted, shift_q} << 1;
    next_scratch = shifted[BCD_W+WIDTH-1:WIDTH];
    next_shift   = shifted[WIDTH-1:0];

    // Position of the most significant nonzero digit, plus one; an all-zero
    // result still reports one digit so the display shows a single '0'.
    next_sig = 3'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (next_scratch[4*i +: 4] != 4'd0) begin
        next_sig = 3'(i + 1);
      end
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          shift_d    = BinIn;
          last_bin_d = BinIn;
          scratch_d  = '0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = next_scratch;
        shift_d   = next_shift;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          bcd_d   = next_scratch;
          sig_d   = next_sig;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset. Reset abandons any
  // conversion in flight and clears the visible result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      last_bin_q <= '0;
      bcd_q      <= '0;
      sig_q      <= 3'd1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      last_bin_q <= last_bin_d;
      bcd_q      <= bcd_d;
      sig_q      <= sig_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Bcd       = bcd_q;
  assign SigDigits = sig_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: doc/bin_to_bcd_converter.md
BIN_TO_BCD_CONVERTER -- requirements
Module: bin_to_bcd_converter

Interface
REQ-001 Parameter WIDTH, default 16: binary input width in bits.
REQ-002 Parameter DIGITS, default 5: BCD output digit count; DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 Clk  input  1: single clock; every register SHALL update on its rising edge only.
REQ-004 Reset  input  1: synchronous, active-high; sampled on the Clk rising edge.
REQ-005 Start  input  1: conversion request; sampled each rising edge.
REQ-006 Auto  input  1: when 1, self-start whenever BinIn differs from the last converted value.
REQ-007 BinIn  input  WIDTH: unsigned binary value to convert (e.g. processor v0/v1 low half).
REQ-008 Bcd  output  4*DIGITS: registered result; digit i at bits [4i+3:4i], digit 0 least significant.
REQ-009 SigDigits  output  3: registered count of significant digits, 1..DIGITS, for leading-zero blanking.
REQ-010 Busy  output  1: high while the block is in state SHIFT.
REQ-011 Done  output  1: one-cycle pulse marking a new valid Bcd/SigDigits.

Function
REQ-012 The block SHALL be a three-state FSM (IDLE, SHIFT, DONE) using shift-and-add-3 (double dabble), one bit per cycle.
REQ-013 IDLE: trigger = Start==1, or Auto==1 and BinIn != LastBin; on trigger at edge k the block SHALL capture BinIn into the shift register and LastBin, clear the scratch BCD, clear the bit counter, and go to SHIFT.
REQ-014 SHIFT: each edge SHALL first add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one; the counter SHALL increment.
REQ-015 After exactly WIDTH shifts (edge k+WIDTH), the block SHALL go to DONE and load the final scratch value into Bcd and the computed significant-digit count into SigDigits on that same edge.
REQ-016 DONE: Done SHALL be 1 for exactly this one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-017 Latency: Done high in the cycle after edge k+WIDTH (16 cycles after the triggering edge at defaults); no trigger is accepted before edge k+WIDTH+1.
REQ-018 Start or Auto triggers in SHIFT or DONE SHALL be ignored, not queued; BinIn changes in those states SHALL NOT affect the conversion in progress.
REQ-019 Start and an Auto trigger in the same IDLE cycle SHALL produce one conversion.
REQ-020 Start==1 held continuously SHALL produce back-to-back conversions, one every WIDTH+2 cycles.
REQ-021 Bcd and SigDigits SHALL hold their last values until the next DONE entry; they SHALL never show partial results.
REQ-022 SigDigits = index of most significant nonzero digit + 1; value 0 SHALL give SigDigits = 1.
REQ-023 Add-3 correction SHALL be 4-bit per digit with no carry between digits; no digit of Bcd SHALL ever exceed 9.
REQ-024 Busy SHALL be 0 in IDLE and DONE; Busy and Done SHALL never be 1 in the same cycle.

Reset
REQ-025 Reset==1 at an edge SHALL force IDLE, Bcd=0, SigDigits=1, LastBin=0, counter=0, Busy=0, Done=0, regardless of state, Start, or Auto.
REQ-026 Reset mid-SHIFT SHALL abort the conversion with no Done pulse; Bcd SHALL read 0 after that edge.
REQ-027 No trigger SHALL be accepted on an edge where Reset==1; triggers are accepted from the first edge with Reset==0.
REQ-028 After reset with Auto==1 and BinIn==0, no conversion SHALL start, because LastBin==0 matches.

Verification
REQ-029 Start pulse with BinIn=1234 -> Busy for 16 cycles, Done 1 cycle, Bcd=0x01234, SigDigits=4.
REQ-030 BinIn=65535 and BinIn=0, each converted with a Start pulse -> Bcd=0x65535, SigDigits=5; then Bcd=0x00000, SigDigits=1.
REQ-031 Start with BinIn=42, then Start with BinIn=99 at cycle 5 of SHIFT and BinIn changed mid-conversion -> single Done, Bcd=0x00042.
REQ-032 Auto=1, Start=0, BinIn steps 7 -> 7 -> 300 -> conversions only on changes: Bcd=0x00007 then 0x00300, two Done pulses total.
REQ-033 Reset asserted at cycle 8 of a conversion of 9999 -> no Done, Bcd=0, Busy=0 next cycle; a fresh Start then gives Bcd=0x09999.
REQ-034 Start held high for 60 cycles with BinIn=5 -> Done pulses every 18 cycles, Bcd=0x00005, Busy/Done never overlap.
